// File: rtl/tap_pkg.sv
// ============================================================================
// Module : tap_pkg
// Brief  : IEEE 1149.1 TAP state encodings and reset constant.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

package tap_pkg;

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0,
        EX1_DR   = 4'h1,
        SH_DR    = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EX2_IR   = 4'h8,
        EX1_IR   = 4'h9,
        SH_IR    = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tapState_t;

    localparam tapState_t TAP_RESET_STATE = TLR;

endpackage

`default_nettype wire

// File: rtl/tap_fsm.sv
// ============================================================================
// Module : tap_fsm
// Brief  : Combinational next-state logic of the 16-state TAP controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tap_fsm
    import tap_pkg::*;
(
    input  logic      TMS,
    input  tapState_t state,
    output tapState_t nextState
);

    always_comb begin
        nextState = TAP_RESET_STATE;
        case (state)
            TLR:      nextState = TMS ? TLR    : RTI;
            RTI:      nextState = TMS ? SEL_DR : RTI;
            SEL_DR:   nextState = TMS ? SEL_IR : CAP_DR;
            CAP_DR:   nextState = TMS ? EX1_DR : SH_DR;
            SH_DR:    nextState = TMS ? EX1_DR : SH_DR;
            EX1_DR:   nextState = TMS ? UPD_DR : PAUSE_DR;
            PAUSE_DR: nextState = TMS ? EX2_DR : PAUSE_DR;
            EX2_DR:   nextState = TMS ? UPD_DR : SH_DR;
            UPD_DR:   nextState = TMS ? SEL_DR : RTI;
            SEL_IR:   nextState = TMS ? TLR    : CAP_IR;
            CAP_IR:   nextState = TMS ? EX1_IR : SH_IR;
            SH_IR:    nextState = TMS ? EX1_IR : SH_IR;
            EX1_IR:   nextState = TMS ? UPD_IR : PAUSE_IR;
            PAUSE_IR: nextState = TMS ? EX2_IR : PAUSE_IR;
            EX2_IR:   nextState = TMS ? UPD_IR : SH_IR;
            UPD_IR:   nextState = TMS ? SEL_DR : RTI;
            default:  nextState = TAP_RESET_STATE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tap_controller.sv
// ============================================================================
// Module : tap_controller
// Brief  : IEEE 1149.1 TAP controller with gated DR/IR capture and update
//          clocks. Define TAP_STATE_DBG_EN to expose the encoded State port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tap_controller
    import tap_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    output logic       ShiftDR,
    output logic       ShiftIR,
    output logic       ClockDR,
    output logic       ClockIR,
    output logic       UpdateDR,
    output logic       UpdateIR,
    output logic       Select,
    output logic       Enable,
    output logic       Reset
`ifdef TAP_STATE_DBG_EN
    ,
    output logic [3:0] State
`endif
);

    tapState_t r_state;
    tapState_t w_nextState;

    logic r_reset;
    logic r_enable;
    logic r_enCdr;
    logic r_enCir;
    logic r_enUdr;
    logic r_enUir;

    tap_fsm u_fsm (
        .TMS       (TMS),
        .state     (r_state),
        .nextState (w_nextState)
    );

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_state <= TAP_RESET_STATE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Enables move only on the falling edge, so the gating below sees them
    // stable for the whole TCK-low phase and cannot glitch.
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_reset  <= 1'b0;
            r_enable <= 1'b0;
            r_enCdr  <= 1'b0;
            r_enCir  <= 1'b0;
            r_enUdr  <= 1'b0;
            r_enUir  <= 1'b0;
        end else begin
            r_reset  <= (r_state != TLR);
            r_enable <= (r_state == SH_DR) || (r_state == SH_IR);
            r_enCdr  <= (r_state == CAP_DR) || (r_state == SH_DR);
            r_enCir  <= (r_state == CAP_IR) || (r_state == SH_IR);
            r_enUdr  <= (r_state == UPD_DR);
            r_enUir  <= (r_state == UPD_IR);
        end
    end

    assign ShiftDR  = (r_state == SH_DR);
    assign ShiftIR  = (r_state == SH_IR);
    assign Select   = (r_state == SEL_IR) || (r_state == CAP_IR) ||
                      (r_state == SH_IR)  || (r_state == EX1_IR) ||
                      (r_state == PAUSE_IR) || (r_state == EX2_IR) ||
                      (r_state == UPD_IR);

    assign ClockDR  = TCK | ~r_enCdr;
    assign ClockIR  = TCK | ~r_enCir;
    assign UpdateDR = ~TCK & r_enUdr;
    assign UpdateIR = ~TCK & r_enUir;

    assign Enable   = r_enable;
    assign Reset    = r_reset;

`ifdef TAP_STATE_DBG_EN
    assign State    = r_state;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tap_controller.sv
// ============================================================================
// Module : tb_tap_controller
// Brief  : Self-checking bench for tap_controller against a table-driven model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_tap_controller;

    logic TCK = 1'b0;
    logic TRST_N;
    logic TMS;
    logic ShiftDR, ShiftIR, ClockDR, ClockIR, UpdateDR, UpdateIR;
    logic Select, Enable, Reset;

    tap_controller dut (
        .TCK      (TCK),
        .TRST_N   (TRST_N),
        .TMS      (TMS),
        .ShiftDR  (ShiftDR),
        .ShiftIR  (ShiftIR),
        .ClockDR  (ClockDR),
        .ClockIR  (ClockIR),
        .UpdateDR (UpdateDR),
        .UpdateIR (UpdateIR),
        .Select   (Select),
        .Enable   (Enable),
        .Reset    (Reset)
    );

    always #3 TCK = ~TCK;

    // Model states: DR column at 2..8, IR column at 9..15 in the same order.
    localparam int S_TLR = 0, S_RTI = 1;
    localparam int S_SELDR = 2, S_CAPDR = 3, S_SHDR = 4, S_UPDDR = 8;
    localparam int S_SELIR = 9, S_CAPIR = 10, S_SHIR = 11, S_UPDIR = 15;

    int nextOn0 [16];
    int nextOn1 [16];
    int mState;

    int checks = 0;
    int errors = 0;
    int cdrLow, cirLow, udrHigh, uirHigh, shDrCnt, shIrCnt;

    function automatic void buildTables();
        nextOn0[S_TLR] = S_RTI;  nextOn1[S_TLR] = S_TLR;
        nextOn0[S_RTI] = S_RTI;  nextOn1[S_RTI] = S_SELDR;
        for (int b = S_SELDR; b <= S_SELIR; b += 7) begin
            // column order: Select, Capture, Shift, Exit1, Pause, Exit2, Update
            nextOn0[b]   = b + 1;  nextOn1[b]   = (b == S_SELDR) ? S_SELIR : S_TLR;
            nextOn0[b+1] = b + 2;  nextOn1[b+1] = b + 3;
            nextOn0[b+2] = b + 2;  nextOn1[b+2] = b + 3;
            nextOn0[b+3] = b + 4;  nextOn1[b+3] = b + 6;
            nextOn0[b+4] = b + 4;  nextOn1[b+4] = b + 5;
            nextOn0[b+5] = b + 2;  nextOn1[b+5] = b + 6;
            nextOn0[b+6] = S_RTI;  nextOn1[b+6] = S_SELDR;
        end
    endfunction

    task automatic clearCounts();
        cdrLow = 0; cirLow = 0; udrHigh = 0; uirHigh = 0; shDrCnt = 0; shIrCnt = 0;
    endtask

    // Enter with TCK low (just after a falling edge); leave the same way.
    task automatic tick(input bit tms);
        logic [6:0] expHigh;
        logic [8:0] expLow;
        logic       inShift;
        TMS = tms;
        @(posedge TCK);
        mState = tms ? nextOn1[mState] : nextOn0[mState];
        #1;
        expHigh = {mState == S_SHDR, mState == S_SHIR, mState >= S_SELIR, 4'b1100};
        checks++;
        if ({ShiftDR, ShiftIR, Select, ClockDR, ClockIR, UpdateDR, UpdateIR} !== expHigh) begin
            errors++;
            $display("FAIL tck_high state=%0d got=%b want=%b", mState,
                     {ShiftDR, ShiftIR, Select, ClockDR, ClockIR, UpdateDR, UpdateIR}, expHigh);
        end
        @(negedge TCK);
        #1;
        inShift = (mState == S_SHDR) || (mState == S_SHIR);
        expLow = {mState == S_SHDR, mState == S_SHIR, mState >= S_SELIR,
                  mState != S_TLR, inShift,
                  !(mState == S_CAPDR || mState == S_SHDR),
                  !(mState == S_CAPIR || mState == S_SHIR),
                  mState == S_UPDDR, mState == S_UPDIR};
        checks++;
        if ({ShiftDR, ShiftIR, Select, Reset, Enable, ClockDR, ClockIR, UpdateDR, UpdateIR} !== expLow) begin
            errors++;
            $display("FAIL tck_low state=%0d got=%b want=%b", mState,
                     {ShiftDR, ShiftIR, Select, Reset, Enable, ClockDR, ClockIR, UpdateDR, UpdateIR},
                     expLow);
        end
        if (!ClockDR)  cdrLow++;
        if (!ClockIR)  cirLow++;
        if (UpdateDR)  udrHigh++;
        if (UpdateIR)  uirHigh++;
        if (ShiftDR)   shDrCnt++;
        if (ShiftIR)   shIrCnt++;
    endtask

    // TRST_N pulse straddling a rising edge: outputs must collapse at once.
    task automatic resetPulse();
        logic [8:0] got;
        #0.5 TRST_N = 1'b0;
        #0.5;
        got = {ShiftDR, ShiftIR, Select, Reset, Enable, ClockDR, ClockIR, UpdateDR, UpdateIR};
        checks++;
        if (got !== 9'b000_00_11_00) begin
            errors++;
            $display("FAIL trst_low_phase got=%b want=%b", got, 9'b000_00_11_00);
        end
        #2;
        got = {ShiftDR, ShiftIR, Select, Reset, Enable, ClockDR, ClockIR, UpdateDR, UpdateIR};
        checks++;
        if (got !== 9'b000_00_11_00) begin
            errors++;
            $display("FAIL trst_high_phase got=%b want=%b", got, 9'b000_00_11_00);
        end
        #0.5 TRST_N = 1'b1;
        mState = S_TLR;
        @(negedge TCK);
        #1;
        checks++;
        if ({Reset, Enable} !== 2'b00) begin
            errors++;
            $display("FAIL trst_after got=%b want=00", {Reset, Enable});
        end
    endtask

    task automatic test_reset();
        logic [8:0] got;
        TRST_N = 1'b0;
        TMS    = 1'b1;
        #1;
        got = {ShiftDR, ShiftIR, Select, Reset, Enable, ClockDR, ClockIR, UpdateDR, UpdateIR};
        checks++;
        if (got !== 9'b000_00_11_00) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", got, 9'b000_00_11_00);
        end
        #3.5 TRST_N = 1'b1;
        mState = S_TLR;
        @(negedge TCK);
        #1;
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
    endtask

    task automatic test_five_ones();
        for (int k = 0; k < 5; k++) tick(1'b1);
        tick(1'b0); tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
        for (int k = 0; k < 5; k++) tick(1'b1);
        checks++;
        if (Reset !== 1'b0) begin
            errors++;
            $display("FAIL five_ones_from_shir Reset=%b want=0", Reset);
        end
    endtask

    task automatic test_dr_scan();
        clearCounts();
        tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
        checks++;
        if ({cdrLow, shDrCnt} !== {32'd3, 32'd2}) begin
            errors++;
            $display("FAIL dr_scan clockdr_lows=%0d shiftdr=%0d want=3,2", cdrLow, shDrCnt);
        end
        checks++;
        if (Enable !== 1'b1) begin
            errors++;
            $display("FAIL dr_scan_enable got=%b want=1", Enable);
        end
    endtask

    task automatic test_dr_pause();
        clearCounts();
        tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b1);
        checks++;
        if ({cdrLow, udrHigh, uirHigh} !== {32'd1, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL dr_pause clockdr_lows=%0d updatedr=%0d updateir=%0d want=1,1,0",
                     cdrLow, udrHigh, uirHigh);
        end
        tick(1'b0);
    endtask

    task automatic test_ir_scan();
        clearCounts();
        tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b1);
        checks++;
        if ({cirLow, uirHigh, cdrLow, udrHigh, shIrCnt} !==
            {32'd3, 32'd1, 32'd0, 32'd0, 32'd2}) begin
            errors++;
            $display("FAIL ir_scan clockir=%0d updateir=%0d clockdr=%0d updatedr=%0d shiftir=%0d",
                     cirLow, uirHigh, cdrLow, udrHigh, shIrCnt);
        end
        tick(1'b0);
    endtask

    task automatic test_select_to_tlr();
        tick(1'b1); tick(1'b1); tick(1'b1);
        checks++;
        if (Reset !== 1'b0) begin
            errors++;
            $display("FAIL sel_to_tlr Reset=%b want=0", Reset);
        end
    endtask

    task automatic test_reset_midshift();
        for (int k = 0; k < 5; k++) tick(1'b1);
        tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0);
        resetPulse();
        tick(1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            tick(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 39) == 0) resetPulse();
            if ($urandom_range(0, 49) == 0) begin
                for (int k = 0; k < 5; k++) tick(1'b1);
                checks++;
                if (Reset !== 1'b0) begin
                    errors++;
                    $display("FAIL random_five_ones Reset=%b want=0", Reset);
                end
            end
        end
    endtask

    initial begin
        buildTables();
        clearCounts();
        test_reset();
        test_five_ones();
        test_dr_scan();
        test_dr_pause();
        test_ir_scan();
        test_select_to_tlr();
        test_reset_midshift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
